adat_frame_parser: RTL and testbench
====================================

# adat_frame_parser

Parses the decoded (post-NRZI) ADAT bit stream into 24-bit channel samples and user bits, tracking frame sync and lock. It sits upstream of the I2S serialiser inside the ADAT receive path. Its input is the bit-recovery stage's one-bit-per-strobe output. Its outputs are parallel samples with channel index and a lock flag that gates the downstream I2S output.

## Interface
- `LOCK_FRAMES`, 2: consecutive clean frames required before `locked_o` asserts (1..7).
- `BIT_TIMEOUT`, 64: `clk_i` cycles without `bit_valid_i` before lock is dropped (2..255).
- `clk_i` in 1: system clock.
- `reset_i` in 1: synchronous, active-high reset.
- `bit_i` in 1: decoded ADAT bit; sampled only when `bit_valid_i`=1.
- `bit_valid_i` in 1: strobe, one per ADAT bit; may be high on consecutive cycles.
- `sample_o` out 24: sample data, MSB = first received bit.
- `sample_ch_o` out 3: channel index of `sample_o`, 0..7.
- `sample_valid_o` out 1: one-cycle pulse; `sample_o` and `sample_ch_o` are valid.
- `user_o` out 4: user bits of the current frame; `user_o[3]` = first received.
- `frame_start_o` out 1: one-cycle pulse when a sync mark is accepted.
- `locked_o` out 1: frame lock.
- `sync_err_o` out 1: one-cycle pulse on any framing violation while not in SEARCH.

## Operation
- Frame is 256 bits:
  - 10×'0' sync, then '1'.
  - 4 user bits, then separator '1'.
  - 8 channels × 6 nibbles, each nibble = 4 data bits + separator '1'.
- State machine states: SEARCH, USER, USER_SEP, DATA, SYNC, SYNC_END. It advances only on `bit_valid_i`=1.
- SEARCH:
  - 4-bit saturating zero counter; a '1' clears it.
  - A '1' with counter ≥10 → USER, pulse `frame_start_o`, clean-frame count = 0.
- USER: shift 4 bits into the user register → USER_SEP.
- USER_SEP:
  - '1' → DATA; `user_o` updates on this edge.
  - '0' → error.
- DATA:
  - Bit counter 0..239. Position p: (p mod 5)=4 is a separator, otherwise data shifted into a 24-bit register.
  - Separator '0' → error.
  - Separator at end of a channel (p mod 30 = 29) with `locked_o`=1: pulse `sample_valid_o` with `sample_ch_o` = p/30.
  - p=239 accepted → SYNC.
- SYNC:
  - Expect 10 zeros, counted 0..9; a '1' → error.
  - After the 10th zero → SYNC_END.
- SYNC_END:
  - '1' → frame clean. Pulse `frame_start_o`, clean count +1 (saturating at `LOCK_FRAMES`), → USER.
  - '0' → error.
- Lock: `locked_o` sets when clean count reaches `LOCK_FRAMES`. It clears on error or timeout.
- Error: pulse `sync_err_o`, clear `locked_o` and clean count, → SEARCH.
  - Zero counter is loaded with 1 if the offending bit was '0', else 0.
  - Samples of the erroring frame already emitted are not retracted.
- Timeout:
  - Idle counter resets on each `bit_valid_i` and saturates.
  - Reaching `BIT_TIMEOUT` → SEARCH, `locked_o`=0, no `sync_err_o`.

## Timing
- All outputs are registered. Every output response appears the cycle after the `clk_i` edge that consumes the triggering `bit_valid_i`.
- `sample_valid_o`, `frame_start_o`, `sync_err_o`: exactly one cycle wide. They are not held across idle cycles.
- `sample_o`, `sample_ch_o`, `user_o`: hold until next update.
- Reset values, all outputs: `sample_o`=0, `sample_ch_o`=0, `sample_valid_o`=0, `user_o`=0, `frame_start_o`=0, `locked_o`=0, `sync_err_o`=0.
- Internal state after reset: SEARCH, all counters 0.
- `reset_i` mid-frame overrides everything and wins over a simultaneous `bit_valid_i`.
- Timeout and `bit_valid_i` in the same cycle: the bit is processed and the idle counter cleared.
- `locked_o` rises in the same cycle as the `frame_start_o` pulse of the `LOCK_FRAMES`-th clean sync end. Samples of that following frame are emitted.
- Throughput: one bit per cycle sustained; 8 samples per 256 strobes.

## Test plan
- Clean stream:
  - Stimulus: 4 frames, channel n = 24'h100000·n + 24'hABCDE, user = 4'b1010, strobes every 4 cycles.
  - Required: `locked_o` rises at the 3rd `frame_start_o`. The next frame yields 8 `sample_valid_o` pulses with correct ch/data. `user_o`=4'hA.
- Back-to-back strobes:
  - Stimulus: same stream with `bit_valid_i` held high continuously.
  - Required: identical samples, with pulses exactly 30 cycles apart within a frame.
- Separator error:
  - Stimulus: flip channel 3, nibble 2 separator to '0' in a locked frame.
  - Required: one `sync_err_o` pulse, `locked_o`=0. Only ch0–2 are emitted. Relock after 2 clean frames.
- Sync violations:
  - Stimulus: 11 zeros before the sync '1' while locked, and separately a '1' at sync position 5.
  - Required: `sync_err_o` each time, and relock takes the full `LOCK_FRAMES`.
- Timeout:
  - Stimulus: stop strobes for 64 cycles while locked.
  - Required: `locked_o` falls on cycle 64, no `sync_err_o`; after resuming, search proceeds.
- Reset:
  - Stimulus: assert `reset_i` for 1 cycle mid-DATA while locked.
  - Required: all outputs 0 the next cycle, and no `sample_valid_o` until relock.

Source files
------------

// File: rtl/adat_frame_parser.sv
// ADAT frame parser: slices the decoded ADAT bit stream into 24-bit channel
// samples and user bits, tracking frame sync and lock.
module adat_frame_parser #(
   parameter int LOCK_FRAMES = 2,
   parameter int BIT_TIMEOUT = 64
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        bit_i,
   input  logic        bit_valid_i,
   output logic [23:0] sample_o,
   output logic [2:0]  sample_ch_o,
   output logic        sample_valid_o,
   output logic [3:0]  user_o,
   output logic        frame_start_o,
   output logic        locked_o,
   output logic        sync_err_o
);
   localparam logic [2:0] LF = 3'(LOCK_FRAMES);
   localparam logic [7:0] TO = 8'(BIT_TIMEOUT);

   typedef enum logic [2:0] {SEARCH, USER, USER_SEP, DATA, SYNC, SYNC_END} state_t;
   state_t state_q, state_d;

   logic [3:0]  zcnt, cnt, user_sr;
   logic [2:0]  nib, slot, ch, clean;
   logic [7:0]  idle;
   logic [23:0] data_sr;
   logic        err, hit, clean_end, timeout;

   always_comb begin
      state_d   = state_q;
      err       = 1'b0;
      hit       = 1'b0;
      clean_end = 1'b0;
      // Fires once, on the idle cycle that brings the counter to saturation.
      timeout   = !bit_valid_i && (idle == TO - 8'd1);
      if (bit_valid_i) begin
         case (state_q)
            SEARCH:   if (bit_i && zcnt >= 4'd10) begin
                         hit     = 1'b1;
                         state_d = USER;
                      end
            USER:     if (cnt == 4'd3) state_d = USER_SEP;
            USER_SEP: if (bit_i) state_d = DATA; else err = 1'b1;
            DATA:     if (nib == 3'd4) begin
                         if (!bit_i) err = 1'b1;
                         else if (slot == 3'd5 && ch == 3'd7) state_d = SYNC;
                      end
            SYNC:     if (bit_i) err = 1'b1;
                      else if (cnt == 4'd9) state_d = SYNC_END;
            SYNC_END: if (bit_i) begin
                         clean_end = 1'b1;
                         state_d   = USER;
                      end else err = 1'b1;
            default:  state_d = SEARCH;
         endcase
      end
      if (err || timeout) state_d = SEARCH;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q        <= SEARCH;
         zcnt           <= '0;
         cnt            <= '0;
         user_sr        <= '0;
         nib            <= '0;
         slot           <= '0;
         ch             <= '0;
         clean          <= '0;
         idle           <= '0;
         data_sr        <= '0;
         sample_o       <= '0;
         sample_ch_o    <= '0;
         sample_valid_o <= 1'b0;
         user_o         <= '0;
         frame_start_o  <= 1'b0;
         locked_o       <= 1'b0;
         sync_err_o     <= 1'b0;
      end else begin
         state_q        <= state_d;
         sample_valid_o <= 1'b0;
         frame_start_o  <= 1'b0;
         sync_err_o     <= 1'b0;
         if (bit_valid_i) idle <= '0;
         else if (idle != TO) idle <= idle + 8'd1;
         if (timeout) begin
            locked_o <= 1'b0;
            clean    <= '0;
            zcnt     <= '0;
         end
         if (bit_valid_i) begin
            case (state_q)
               SEARCH: begin
                  if (bit_i) zcnt <= '0;
                  else if (zcnt != 4'd15) zcnt <= zcnt + 4'd1;
                  if (hit) begin
                     frame_start_o <= 1'b1;
                     clean         <= '0;
                     cnt           <= '0;
                  end
               end
               USER: begin
                  user_sr <= {user_sr[2:0], bit_i};
                  cnt     <= cnt + 4'd1;
               end
               USER_SEP: if (bit_i) begin
                  user_o <= user_sr;
                  nib    <= '0;
                  slot   <= '0;
                  ch     <= '0;
               end
               DATA: begin
                  if (nib != 3'd4) begin
                     data_sr <= {data_sr[22:0], bit_i};
                     nib     <= nib + 3'd1;
                  end else begin
                     nib <= '0;
                     if (slot == 3'd5) begin
                        slot <= '0;
                        ch   <= ch + 3'd1;
                        cnt  <= '0;
                        if (locked_o && bit_i) begin
                           sample_o       <= data_sr;
                           sample_ch_o    <= ch;
                           sample_valid_o <= 1'b1;
                        end
                     end else slot <= slot + 3'd1;
                  end
               end
               SYNC: cnt <= cnt + 4'd1;
               SYNC_END: if (clean_end) begin
                  frame_start_o <= 1'b1;
                  cnt           <= '0;
                  if (clean != LF) clean <= clean + 3'd1;
                  if (clean >= LF - 3'd1) locked_o <= 1'b1;
               end
               default: ;
            endcase
            // A '0' that breaks framing may itself be the first sync zero.
            if (err) begin
               sync_err_o <= 1'b1;
               locked_o   <= 1'b0;
               clean      <= '0;
               zcnt       <= bit_i ? 4'd0 : 4'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_adat_frame_parser.sv
// Randomized bench for adat_frame_parser against a frame-position reference model.
module tb_adat_frame_parser;
   localparam int LF     = 2;
   localparam int BIT_TO = 64;

   logic        clk_i = 1'b0;
   logic        reset_i, bit_i, bit_valid_i;
   logic [23:0] sample_o;
   logic [2:0]  sample_ch_o;
   logic        sample_valid_o, frame_start_o, locked_o, sync_err_o;
   logic [3:0]  user_o;

   adat_frame_parser #(.LOCK_FRAMES(LF), .BIT_TIMEOUT(BIT_TO)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .bit_i(bit_i), .bit_valid_i(bit_valid_i),
      .sample_o(sample_o), .sample_ch_o(sample_ch_o), .sample_valid_o(sample_valid_o),
      .user_o(user_o), .frame_start_o(frame_start_o), .locked_o(locked_o),
      .sync_err_o(sync_err_o));

   always #5 clk_i = ~clk_i;

   int n_chk = 0, n_pass = 0, n_sv = 0, e_nsv = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
   endtask

   // Reference model: tracks the bit's position inside the 256-bit frame
   // (sync '1' at position 10) and applies the framing rules arithmetically.
   bit          m_search;
   int          m_pos, m_zrun, m_clean, m_idle;
   logic [3:0]  m_ucol;
   logic [23:0] m_data;
   logic [23:0] e_sample;
   logic [2:0]  e_ch;
   logic [3:0]  e_user;
   logic        e_sv, e_fs, e_lock, e_err;

   task automatic model(input logic r, input logic v, input logic b);
      bit bad;
      int p;
      e_fs = 0; e_err = 0; e_sv = 0;
      if (r) begin
         e_sample = 0; e_ch = 0; e_user = 0; e_lock = 0;
         m_search = 1; m_zrun = 0; m_clean = 0; m_idle = 0;
         return;
      end
      if (!v) begin
         if (m_idle < BIT_TO) begin
            m_idle++;
            if (m_idle == BIT_TO) begin
               m_search = 1; e_lock = 0; m_clean = 0; m_zrun = 0;
            end
         end
         return;
      end
      m_idle = 0;
      if (m_search) begin
         if (!b) m_zrun = (m_zrun < 15) ? m_zrun + 1 : 15;
         else begin
            if (m_zrun >= 10) begin
               m_search = 0; m_pos = 11; e_fs = 1; m_clean = 0;
            end
            m_zrun = 0;
         end
         return;
      end
      bad = 0;
      if (m_pos < 15) m_ucol = {m_ucol[2:0], b};
      else if (m_pos == 15) begin
         if (b) e_user = m_ucol; else bad = 1;
      end else if (m_pos < 256) begin
         p = m_pos - 16;
         if (p % 5 != 4) m_data = {m_data[22:0], b};
         else if (!b) bad = 1;
         else if (p % 30 == 29 && e_lock) begin
            e_sv = 1; e_sample = m_data; e_ch = 3'(p / 30); e_nsv++;
         end
      end else if (m_pos < 266) begin
         if (b) bad = 1;
      end else begin
         if (b) begin
            e_fs = 1;
            if (m_clean < LF) m_clean++;
            if (m_clean == LF) e_lock = 1;
            m_pos = 10;
         end else bad = 1;
      end
      if (bad) begin
         e_err = 1; e_lock = 0; m_clean = 0; m_search = 1; m_zrun = b ? 0 : 1;
      end else m_pos++;
   endtask

   task automatic cyc(input logic r, input logic v, input logic b);
      reset_i = r; bit_valid_i = v; bit_i = b;
      @(posedge clk_i);
      model(r, v, b);
      #1;
      chk("outs", {29'd0, sample_o, sample_ch_o, user_o, locked_o, frame_start_o, sync_err_o, sample_valid_o},
                  {29'd0, e_sample, e_ch, e_user, e_lock, e_fs, e_err, e_sv});
      if (sample_valid_o) n_sv++;
   endtask

   logic        q[$];
   logic [23:0] chd[8];

   task automatic push_frame(input logic [3:0] u, input int flip, input bit extra0);
      logic f[$];
      logic [23:0] d;
      repeat (10) f.push_back(1'b0);
      if (extra0) f.push_back(1'b0);
      f.push_back(1'b1);
      for (int i = 3; i >= 0; i--) f.push_back(u[i]);
      f.push_back(1'b1);
      for (int c = 0; c < 8; c++) begin
         d = chd[c];
         for (int n = 0; n < 6; n++) begin
            for (int k = 0; k < 4; k++) f.push_back(d[23 - 4*n - k]);
            f.push_back(1'b1);
         end
      end
      if (flip >= 0) f[flip] = ~f[flip];
      foreach (f[i]) q.push_back(f[i]);
   endtask

   task automatic plan_data();
      for (int c = 0; c < 8; c++) chd[c] = 24'h100000 * c + 24'hABCDE;
   endtask

   task automatic rand_data();
      for (int c = 0; c < 8; c++) chd[c] = 24'($urandom);
   endtask

   // mode 0: strobe every 4 cycles, 1: back-to-back, 2: random gaps.
   // kind 1: idle gap long enough to time out, 2: reset pulse with a strobe.
   task automatic play(input int mode, input int evt_at, input int kind);
      int gap;
      for (int i = 0; i < q.size(); i++) begin
         if (i == evt_at) begin
            if (kind == 1) repeat (BIT_TO + 6) cyc(1'b0, 1'b0, 1'b0);
            else if (kind == 2) cyc(1'b1, 1'b1, 1'b1);
         end
         gap = (mode == 0) ? 3 : (mode == 1) ? 0 : int'($urandom_range(0, 3));
         repeat (gap) cyc(1'b0, 1'b0, 1'b0);
         cyc(1'b0, 1'b1, q[i]);
      end
      q.delete();
   endtask

   initial begin
      int kind, flip;
      bit x0;
      reset_i = 1'b1; bit_valid_i = 1'b0; bit_i = 1'b0;
      m_ucol = 0; m_data = 0; m_pos = 0;
      model(1'b1, 1'b0, 1'b0);
      repeat (3) cyc(1'b1, 1'b0, 1'b0);

      plan_data();
      repeat (4) push_frame(4'b1010, -1, 0);
      play(0, -1, 0);

      cyc(1'b1, 1'b0, 1'b0);
      repeat (4) push_frame(4'b1010, -1, 0);
      play(1, -1, 0);

      // Separator of channel 3, nibble 2 flipped to '0'.
      rand_data();
      push_frame(4'h3, -1, 0);
      push_frame(4'h5, 16 + 3*30 + 2*5 + 4, 0);
      repeat (3) push_frame(4'hC, -1, 0);
      play(2, -1, 0);

      // Eleven sync zeros, then a '1' at sync position 5.
      push_frame(4'h1, -1, 0);
      push_frame(4'h2, -1, 1);
      repeat (3) push_frame(4'h4, -1, 0);
      push_frame(4'h6, 5, 0);
      repeat (3) push_frame(4'h7, -1, 0);
      play(2, -1, 0);

      repeat (5) push_frame(4'h9, -1, 0);
      play(2, 256 + 100, 1);
      repeat (5) push_frame(4'hE, -1, 0);
      play(2, 256 + 100, 2);

      for (int f = 0; f < 10; f++) begin
         rand_data();
         kind = $urandom_range(0, 5);
         flip = (kind == 3) ? int'($urandom_range(0, 255)) : -1;
         x0   = (kind == 4);
         push_frame(4'($urandom), flip, x0);
         play(2, (kind == 5) ? int'($urandom_range(0, 255)) : -1, 1);
      end

      chk("sv_total", 64'(n_sv), 64'(e_nsv));
      chk("samples_seen", 64'(n_sv != 0), 64'd1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
